axi_cache_bridge: RTL
=====================

// Module: axi_cache_bridge
// PURPOSE
//  Parametrised bridge between the core's cache refill/writeback interfaces (icache, dcache, ...)
//  and the core_top AXI3 master ports. It replaces the unconnected rd_*/wr_* cache ports with
//  NUM_RD read requesters arbitrated round-robin, one outstanding read per requester returned by
//  ID, and a single-entry write buffer that issues INCR bursts (line writeback or uncached store).
// PARAMETERS
//  NUM_RD      2   read requesters; port i uses arid=i (0=icache, 1=dcache); NUM_RD<=16
//  LINE_WORDS  4   32-bit words per cache line; power of two, 2..16
//  WR_ID       1   AXI awid/wid for all writes
// PORTS
//  aclk        in   1                clock
//  aresetn     in   1                asynchronous reset, active low
//  rd_req      in   NUM_RD           per-port read request
//  rd_type     in   3*NUM_RD         0 byte, 1 half, 2 word, 4 cache line
//  rd_addr     in   32*NUM_RD        read address, line-aligned when rd_type=4
//  rd_rdy      out  NUM_RD           request accepted when rd_req&rd_rdy
//  ret_valid   out  NUM_RD           beat for port i (rvalid & rid==i)
//  ret_last    out  1                final beat (rlast)
//  ret_data    out  32               beat data, shared by all ports
//  wr_req      in   1                write request
//  wr_type     in   3                as rd_type
//  wr_addr     in   32               write address
//  wr_wstrb    in   4                byte strobe for non-line writes; line writes use 4'hF
//  wr_data     in   32*LINE_WORDS    word k in bits [32k+31:32k]; only word 0 used when non-line
//  wr_rdy      out  1                write buffer empty
//  ar*/r*/aw*/w*/b*  AXI3 master channels as named on core_top (arid..bready)
// BEHAVIOUR
//  Reset: all *valid, rd_rdy, wr_rdy, ret_valid = 0; pend[] = 0; rr_ptr = 0; FSMs in IDLE.
//  Constants: arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0,
//   rready=1, bready=1 in W_B state only.
//  AR FSM AR_IDLE/AR_BUSY:
//   - In AR_IDLE, grant = first requesting port i with ~pend[i] at or after rr_ptr.
//     rd_rdy[grant]=1 combinationally; all other rd_rdy bits are 0.
//   - On accept: latch arid=i, araddr, arlen (LINE_WORDS-1 for line, else 0),
//     arsize (2 for line, else rd_type[1:0]); set pend[i]; rr_ptr <= i+1 mod NUM_RD;
//     go to AR_BUSY with arvalid=1.
//   - arvalid and all AR fields stay stable until arready; then return to AR_IDLE.
//     The next grant is possible the cycle after the handshake.
//  R path: ret_valid[i]=rvalid&(rid==i); ret_data=rdata; ret_last=rlast.
//   pend[rid] is cleared on rvalid&rlast. Beats of different IDs may interleave.
//   A rid with pend clear is ignored.
//  Write FSM W_IDLE/W_SEND/W_B:
//   - wr_rdy=1 only in W_IDLE. On wr_req, capture address/type/strobe/data and set
//     awvalid=1 and wvalid=1 in the same cycle (W_SEND).
//   - AW and W handshakes are independent. The beat counter advances on wvalid&wready.
//   - wdata = buffered word[cnt]; wstrb = 4'hF for line, else wr_wstrb.
//   - wlast=1 only when cnt=awlen. awlen/awsize are encoded as for reads.
//   - Go to W_B once both AW accepted and the wlast beat accepted (either order).
//   - In W_B, bready=1; on bvalid go to W_IDLE (wr_rdy=1 the next cycle).
//     bresp is ignored.
//  Simultaneous rd accept and wr accept in one cycle: both proceed, since the channels are
//   independent.
//  aresetn low mid-burst: outputs drop asynchronously. In-flight AXI transactions are
//   abandoned, and the whole system is reset together.
// CONFIGURATION
//  `define AXI_BRIDGE_RAW_CHECK_EN:
//   - When defined, a read whose line address (addr[31:log2(4*LINE_WORDS)]) matches the
//     buffered write while the write FSM is not in W_IDLE is not granted (rd_rdy=0).
//     It is granted after bvalid.
//   - When not defined, reads are never blocked by writes; the caches guarantee ordering.
// TESTING
//  1 Port0 line read 0x1c000040, arready=1 -> arid=0, araddr=0x1c000040, arlen=3, arsize=2;
//    4 beats ret_valid[0]=1, ret_last on beat 4 only, pend[0] cleared.
//  2 rd_req=2'b11 first cycle after reset -> port0 granted, port1 granted the cycle after
//    AR handshake. Interleaved rid 1,0,1,0 beats routed to ret_valid[1]/[0] correctly.
//  3 Word write 0xbfaf8000, wstrb=4'h3, wr_type=2 -> awlen=0, awsize=2, one W beat with
//    wlast=1, wstrb=3. wr_rdy=0 until bvalid, then 1 the following cycle.
//  4 Line write with wready toggling 1,0,1,0.. and awready delayed 5 cycles ->
//    words 0..3 in order, wlast only on word 3, W_B entered after both handshakes.
//  5 RAW_CHECK_EN: line write 0x100 pending, port1 word read 0x104 -> rd_rdy[1]=0 until
//    bvalid. Without the macro, rd_rdy[1]=1 immediately.
//  6 aresetn=0 during beat 2 of a read burst -> arvalid/awvalid/wvalid/ret_valid=0 at once;
//    after release the next rd_req is granted to port0.

Source files
------------

// File: rtl/axi_cache_bridge.sv
// axi_cache_bridge: round-robin AXI3 read arbiter for cache requesters plus a single-entry write buffer.
// Optional define AXI_BRIDGE_RAW_CHECK_EN holds off reads that hit the line sitting in the write buffer.
module axi_cache_bridge #(
   parameter int         NUM_RD     = 2,
   parameter int         LINE_WORDS = 4,
   parameter logic [3:0] WR_ID      = 4'd1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NUM_RD-1:0]          rd_req,
   input  logic [3*NUM_RD-1:0]        rd_type,
   input  logic [32*NUM_RD-1:0]       rd_addr,
   output logic [NUM_RD-1:0]          rd_rdy,
   output logic [NUM_RD-1:0]          ret_valid,
   output logic                       ret_last,
   output logic [31:0]                ret_data,
   input  logic                       wr_req,
   input  logic [2:0]                 wr_type,
   input  logic [31:0]                wr_addr,
   input  logic [3:0]                 wr_wstrb,
   input  logic [32*LINE_WORDS-1:0]   wr_data,
   output logic                       wr_rdy,
   output logic [3:0]                 arid,
   output logic [31:0]                araddr,
   output logic [3:0]                 arlen,
   output logic [2:0]                 arsize,
   output logic [1:0]                 arburst,
   output logic [1:0]                 arlock,
   output logic [3:0]                 arcache,
   output logic [2:0]                 arprot,
   output logic                       arvalid,
   input  logic                       arready,
   input  logic [3:0]                 rid,
   input  logic [31:0]                rdata,
   input  logic [1:0]                 rresp,
   input  logic                       rlast,
   input  logic                       rvalid,
   output logic                       rready,
   output logic [3:0]                 awid,
   output logic [31:0]                awaddr,
   output logic [3:0]                 awlen,
   output logic [2:0]                 awsize,
   output logic [1:0]                 awburst,
   output logic [1:0]                 awlock,
   output logic [3:0]                 awcache,
   output logic [2:0]                 awprot,
   output logic                       awvalid,
   input  logic                       awready,
   output logic [3:0]                 wid,
   output logic [31:0]                wdata,
   output logic [3:0]                 wstrb,
   output logic                       wlast,
   output logic                       wvalid,
   input  logic                       wready,
   input  logic [3:0]                 bid,
   input  logic [1:0]                 bresp,
   input  logic                       bvalid,
   output logic                       bready
);
   localparam int CW  = $clog2(LINE_WORDS);
   localparam int LSB = $clog2(4*LINE_WORDS);

   typedef enum logic       {AR_IDLE, AR_BUSY}       ar_state_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_B}    w_state_t;

   ar_state_t               ar_state_r, ar_next_s;
   w_state_t                w_state_r, w_next_s;
   logic [NUM_RD-1:0]       pend_r, blocked_s, elig_s;
   logic [2*NUM_RD-1:0]     rot_s;
   logic [3:0]              rr_ptr_r, grant_idx_s;
   logic [4:0]              sum_s;
   logic                    found_s, rd_accept_s, wr_accept_s;
   logic [31:0]             sel_addr_s;
   logic [2:0]              sel_type_s;
   logic [31:0]             wa_r;
   logic [3:0]              awlen_r, wstrb_r;
   logic [2:0]              awsize_r;
   logic [32*LINE_WORDS-1:0] wbuf_r;
   logic [CW-1:0]           cnt_r;
   logic                    aw_done_r, w_done_r, aw_fire_s, w_fire_s;
   logic                    unused_s;

   assign unused_s = ^{rresp, bresp, bid};

`ifdef AXI_BRIDGE_RAW_CHECK_EN
   // A read to the buffered line waits until the write response has come back.
   always_comb begin
      blocked_s = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         blocked_s[k] = (w_state_r != W_IDLE) && (rd_addr[k*32+LSB +: 32-LSB] == wa_r[31:LSB]);
      end
   end
`else
   assign blocked_s = '0;
`endif

   // Rotate the eligible mask so bit 0 is rr_ptr, then take the first set bit.
   always_comb begin
      elig_s      = rd_req & ~pend_r & ~blocked_s;
      rot_s       = {elig_s, elig_s} >> rr_ptr_r;
      found_s     = 1'b0;
      grant_idx_s = 4'd0;
      sum_s       = 5'd0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (!found_s && rot_s[k]) begin
            found_s     = 1'b1;
            sum_s       = {1'b0, rr_ptr_r} + 5'(k);
            grant_idx_s = (sum_s >= 5'(NUM_RD)) ? 4'(sum_s - 5'(NUM_RD)) : sum_s[3:0];
         end else begin
            sum_s = sum_s;
         end
      end
      sel_addr_s = 32'd0;
      sel_type_s = 3'd0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (grant_idx_s == 4'(k)) begin
            sel_addr_s = rd_addr[k*32 +: 32];
            sel_type_s = rd_type[k*3 +: 3];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd_rdy[k]    = aresetn && found_s && (ar_state_r == AR_IDLE) && (grant_idx_s == 4'(k));
         ret_valid[k] = rvalid && (rid == 4'(k)) && pend_r[k];
      end
   end

   assign rd_accept_s = |(rd_req & rd_rdy);
   assign ret_data    = rdata;
   assign ret_last    = rlast;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) ar_state_r <= AR_IDLE;
      else          ar_state_r <= ar_next_s;
   end

   always_comb begin
      ar_next_s = ar_state_r;
      case (ar_state_r)
         AR_IDLE: if (rd_accept_s) ar_next_s = AR_BUSY; else ar_next_s = AR_IDLE;
         AR_BUSY: if (arready)     ar_next_s = AR_IDLE; else ar_next_s = AR_BUSY;
         default: ar_next_s = AR_IDLE;
      endcase
   end

   always_comb begin
      case (ar_state_r)
         AR_BUSY: arvalid = 1'b1;
         default: arvalid = 1'b0;
      endcase
   end

   // AR fields are captured at grant and held until the handshake.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         arid     <= 4'd0;
         araddr   <= 32'd0;
         arlen    <= 4'd0;
         arsize   <= 3'd0;
         rr_ptr_r <= 4'd0;
      end else if (rd_accept_s) begin
         arid     <= grant_idx_s;
         araddr   <= sel_addr_s;
         arlen    <= (sel_type_s == 3'd4) ? 4'(LINE_WORDS-1) : 4'd0;
         arsize   <= (sel_type_s == 3'd4) ? 3'd2 : {1'b0, sel_type_s[1:0]};
         rr_ptr_r <= (grant_idx_s == 4'(NUM_RD-1)) ? 4'd0 : grant_idx_s + 4'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_r <= '0;
      end else begin
         for (int k = 0; k < NUM_RD; k++) begin
            if (rd_accept_s && (grant_idx_s == 4'(k)))        pend_r[k] <= 1'b1;
            else if (rvalid && rlast && (rid == 4'(k)))       pend_r[k] <= 1'b0;
            else                                              pend_r[k] <= pend_r[k];
         end
      end
   end

   assign rready  = 1'b1;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign wr_accept_s = wr_req && (w_state_r == W_IDLE);
   assign aw_fire_s   = awvalid && awready;
   assign w_fire_s    = wvalid && wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state_r <= W_IDLE;
      else          w_state_r <= w_next_s;
   end

   // AW and W complete independently; W_B needs both.
   always_comb begin
      w_next_s = w_state_r;
      case (w_state_r)
         W_IDLE:  if (wr_req) w_next_s = W_SEND; else w_next_s = W_IDLE;
         W_SEND:  if ((aw_done_r || aw_fire_s) && (w_done_r || (w_fire_s && wlast)))
                     w_next_s = W_B;
                  else
                     w_next_s = W_SEND;
         W_B:     if (bvalid) w_next_s = W_IDLE; else w_next_s = W_B;
         default: w_next_s = W_IDLE;
      endcase
   end

   always_comb begin
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      wr_rdy  = 1'b0;
      case (w_state_r)
         W_IDLE:  wr_rdy = aresetn;
         W_SEND:  begin awvalid = !aw_done_r; wvalid = !w_done_r; end
         W_B:     bready = 1'b1;
         default: wr_rdy = 1'b0;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wa_r      <= 32'd0;
         awlen_r   <= 4'd0;
         awsize_r  <= 3'd0;
         wstrb_r   <= 4'd0;
         wbuf_r    <= '0;
         cnt_r     <= '0;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else if (wr_accept_s) begin
         wa_r      <= wr_addr;
         awlen_r   <= (wr_type == 3'd4) ? 4'(LINE_WORDS-1) : 4'd0;
         awsize_r  <= (wr_type == 3'd4) ? 3'd2 : {1'b0, wr_type[1:0]};
         wstrb_r   <= (wr_type == 3'd4) ? 4'hF : wr_wstrb;
         wbuf_r    <= wr_data;
         cnt_r     <= '0;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else if (w_state_r == W_SEND) begin
         if (aw_fire_s) aw_done_r <= 1'b1;
         if (w_fire_s && wlast)  w_done_r <= 1'b1;
         else if (w_fire_s)      cnt_r    <= cnt_r + CW'(1);
      end
   end

   always_comb begin
      wdata = 32'd0;
      for (int k = 0; k < LINE_WORDS; k++) begin
         if (cnt_r == CW'(k)) wdata = wbuf_r[k*32 +: 32];
         else                 wdata = wdata;
      end
   end

   assign wlast   = (4'(cnt_r) == awlen_r);
   assign wstrb   = wstrb_r;
   assign awaddr  = wa_r;
   assign awlen   = awlen_r;
   assign awsize  = awsize_r;
   assign awid    = WR_ID;
   assign wid     = WR_ID;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
endmodule
